// File: rtl/sr_ctrl_pkg.sv
// Shared types for the shift-register sequencer.
package sr_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } sr_state_e;

  // Frame direction, latched when a frame is accepted.
  typedef enum logic {
    PISO = 1'b0,
    SIPO = 1'b1
  } sr_mode_e;

  // Prescaler width. Kept at least one bit so DIV=1 still gets a legal vector.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/shift_counter.sv
// Prescaler plus bit counter. Emits one tick every DIV enabled cycles and
// counts ticks modulo WIDTH; last marks the WIDTH-th tick of a frame.
module shift_counter
  import sr_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic             tick,
  output logic             last,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int PW = presc_width(DIV);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WIDTH - 1);

  logic [PW-1:0] presc;

  // Tick and last are decoded from registered counters gated by the
  // (registered) enable, so they carry no input-to-output path.
  always_comb begin
    tick = en && (presc == PRESC_MAX);
    last = tick && (bit_cnt == CNT_MAX);
  end

  // Prescaler and bit counter; clr wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      presc   <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      if (presc == PRESC_MAX) begin
        presc   <= '0;
        bit_cnt <= (bit_cnt == CNT_MAX) ? '0 : bit_cnt + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_reg_ctrl.sv
// Frame sequencer for the SIPO/PISO datapath: drives load, shift and out
// strobes for one WIDTH-bit frame per accepted start.
//
// Handshake: start is a request qualified by ready. A frame is accepted on
// the rising edge where start=1, ready=1 and abort=0; any other start is
// dropped, never queued. ready is high only in IDLE and DONE.
module shift_reg_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             load,
  output logic             shift,
  output logic             out,
  output logic [CNT_W-1:0] bit_cnt,
  output sr_state_e        dbg_state
);

  sr_state_e state, state_next;
  sr_mode_e  mode_q;
  logic      accept;
  logic      cnt_en;
  logic      cnt_clr;
  logic      tick;
  logic      last;

  shift_counter #(
    .WIDTH(WIDTH),
    .DIV  (DIV)
  ) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .tick   (tick),
    .last   (last),
    .bit_cnt(bit_cnt)
  );

  // State register and mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= PISO;
    end else begin
      state <= state_next;
      if (accept) mode_q <= sr_mode_e'(mode);
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start && !abort) begin
          accept     = 1'b1;
          state_next = mode ? SHIFT : LOAD;
        end
      end
      LOAD:    state_next = abort ? IDLE : SHIFT;
      SHIFT: begin
        if (abort)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter control: runs only in SHIFT; held clear elsewhere so the
  // prescaler starts from zero on every entry and abort zeroes bit_cnt.
  always_comb begin
    cnt_en  = (state == SHIFT);
    cnt_clr = abort || (state != SHIFT);
  end

  // Moore output decode from registered state.
  always_comb begin
    ready     = (state == IDLE) || (state == DONE);
    busy      = (state == LOAD) || (state == SHIFT);
    load      = (state == LOAD) && (mode_q == PISO);
    shift     = tick;
    out       = (state == DONE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl: two instances (DIV=1 and DIV=3) share
// stimulus; each scenario checks the cycle-by-cycle strobe pattern.
module tb_shift_reg_ctrl;
  import sr_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n, start, mode, abort;

  logic       a_ready, a_busy, a_load, a_shift, a_out;
  logic [2:0] a_cnt;
  sr_state_e  a_state;
  logic       b_ready, b_busy, b_load, b_shift, b_out;
  logic [2:0] b_cnt;
  sr_state_e  b_state;

  int checks = 0;
  int errors = 0;

  // Clock generation.
  always #5 clk = ~clk;

  shift_reg_ctrl #(.WIDTH(8), .DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
    .ready(a_ready), .busy(a_busy), .load(a_load), .shift(a_shift),
    .out(a_out), .bit_cnt(a_cnt), .dbg_state(a_state)
  );

  shift_reg_ctrl #(.WIDTH(8), .DIV(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
    .ready(b_ready), .busy(b_busy), .load(b_load), .shift(b_shift),
    .out(b_out), .bit_cnt(b_cnt), .dbg_state(b_state)
  );

  // Advance to 1 time unit after the next rising edge (start of next cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset both instances; returns positioned at cycle 0 of an idle design.
  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [7:0] e, o;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = 8'b1000_0000;
    o = {a_ready, a_busy, a_load, a_shift, a_out, a_cnt};
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_a got %b exp %b", o, e); end
    o = {b_ready, b_busy, b_load, b_shift, b_out, b_cnt};
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_b got %b exp %b", o, e); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_piso_div1();
    logic [7:0] e, o;
    apply_reset();
    for (int c = 0; c <= 11; c++) begin
      start = (c == 0); mode = 1'b0; abort = 1'b0;
      @(negedge clk);
      e = {(c == 0 || c >= 10), (c >= 1 && c <= 9), (c == 1), (c >= 2 && c <= 9),
           (c == 10), (c >= 2 && c <= 9) ? 3'(c - 2) : 3'd0};
      o = {a_ready, a_busy, a_load, a_shift, a_out, a_cnt};
      checks++;
      if (o !== e) begin errors++; $display("FAIL piso_div1 c%0d got %b exp %b", c, o, e); end
      step();
    end
  endtask

  task automatic test_sipo_div3();
    logic [7:0] e, o;
    apply_reset();
    for (int c = 0; c <= 26; c++) begin
      start = (c == 0); mode = 1'b1; abort = 1'b0;
      @(negedge clk);
      e = {(c == 0 || c >= 25), (c >= 1 && c <= 24), 1'b0,
           (c >= 3 && c <= 24 && (c % 3) == 0), (c == 25),
           (c >= 1 && c <= 24) ? 3'((c - 1) / 3) : 3'd0};
      o = {b_ready, b_busy, b_load, b_shift, b_out, b_cnt};
      checks++;
      if (o !== e) begin errors++; $display("FAIL sipo_div3 c%0d got %b exp %b", c, o, e); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, o;
    int p;
    apply_reset();
    for (int c = 0; c <= 21; c++) begin
      start = (c <= 19); mode = 1'b0; abort = 1'b0;
      @(negedge clk);
      if (c == 0 || c == 21) begin
        e = 8'b1000_0000;
      end else begin
        p = ((c - 1) % 10) + 1;
        e = {(p == 10), (p <= 9), (p == 1), (p >= 2 && p <= 9), (p == 10),
             (p >= 2 && p <= 9) ? 3'(p - 2) : 3'd0};
      end
      o = {a_ready, a_busy, a_load, a_shift, a_out, a_cnt};
      checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back c%0d got %b exp %b", c, o, e); end
      step();
    end
  endtask

  task automatic test_abort();
    logic [7:0] e, o;
    apply_reset();
    for (int c = 0; c <= 8; c++) begin
      start = (c == 0 || c == 6); mode = 1'b0; abort = (c == 5);
      @(negedge clk);
      case (c)
        0, 6:    e = 8'b1000_0000;
        1, 7:    e = 8'b0110_0000;
        default: e = {2'b01, 1'b0, 1'b1, 1'b0, (c == 8) ? 3'd0 : 3'(c - 2)};
      endcase
      o = {a_ready, a_busy, a_load, a_shift, a_out, a_cnt};
      checks++;
      if (o !== e) begin errors++; $display("FAIL abort c%0d got %b exp %b", c, o, e); end
      step();
    end
  endtask

  task automatic test_abort_idle();
    logic [7:0] o;
    apply_reset();
    start = 1'b1; abort = 1'b1; mode = 1'b0;
    step();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    o = {a_ready, a_busy, a_load, a_shift, a_out, a_cnt};
    checks++;
    if (o !== 8'b1000_0000) begin errors++; $display("FAIL abort_idle got %b exp 10000000", o); end
    step();
  endtask

  task automatic test_ignore_start();
    logic [7:0] e, o;
    int outs = 0;
    apply_reset();
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0 || c == 3 || c == 5);
      mode  = (c == 4 || c == 6 || c == 3);
      abort = 1'b0;
      if (c == 0) mode = 1'b0;
      @(negedge clk);
      e = {(c == 0 || c >= 10), (c >= 1 && c <= 9), (c == 1), (c >= 2 && c <= 9),
           (c == 10), (c >= 2 && c <= 9) ? 3'(c - 2) : 3'd0};
      o = {a_ready, a_busy, a_load, a_shift, a_out, a_cnt};
      if (a_out === 1'b1) outs++;
      checks++;
      if (o !== e) begin errors++; $display("FAIL ignore_start c%0d got %b exp %b", c, o, e); end
      step();
    end
    checks++;
    if (outs != 1) begin errors++; $display("FAIL ignore_start_outs got %0d exp 1", outs); end
  endtask

  task automatic test_async_reset();
    logic [7:0] e, o;
    apply_reset();
    for (int c = 0; c <= 4; c++) begin
      start = (c == 0); mode = 1'b0; abort = 1'b0;
      step();
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    o = {a_ready, a_busy, a_load, a_shift, a_out, a_cnt};
    checks++;
    if (o !== 8'b1000_0000) begin errors++; $display("FAIL async_reset got %b exp 10000000", o); end
    #1 rst_n = 1'b1;
    step();
    for (int c = 0; c <= 3; c++) begin
      start = (c == 0); mode = 1'b0; abort = 1'b0;
      @(negedge clk);
      case (c)
        0:       e = 8'b1000_0000;
        1:       e = 8'b0110_0000;
        default: e = {5'b01010, 3'(c - 2)};
      endcase
      o = {a_ready, a_busy, a_load, a_shift, a_out, a_cnt};
      checks++;
      if (o !== e) begin errors++; $display("FAIL async_restart c%0d got %b exp %b", c, o, e); end
      step();
    end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_piso_div1();
    test_sipo_div3();
    test_back_to_back();
    test_abort();
    test_abort_idle();
    test_ignore_start();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
